bp_update_ctrl: RTL

- Sequences all writes into the branch predictor's counter and history tables.
- After reset, and on request, it sweeps every table entry to a known state.
- Resolved-branch updates from EX are buffered in a small FIFO and issued to the predictor one per cycle while the sweep is not running.
- Keeps saturating branch and misprediction counters for the debug/status bus.

---
 rtl/bp_update_ctrl.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/bp_update_ctrl.sv
// bp_update_ctrl: sequences every write into the branch predictor's counter
// and history tables.
//   - After reset or flush_req, sweeps all 2^(PC_W+HIST_W) counter entries to
//     2'b01 and every history entry to 0 (BOOT -> SWEEP -> RUN).
//   - Resolved-branch updates from EX are buffered in a small FIFO and
//     issued to the predictor one per cycle while in RUN.
//   - Keeps saturating branch / misprediction counters for the status bus.
// Ports:
//   clk, rstn                       clock, async active-low reset
//   flush_req                       re-initialise tables, drop queued updates
//   upd_valid/upd_pc/upd_taken/
//   upd_mispredict, upd_ready       update push handshake from EX
//   rec_we/rec_pc/rec_data          predictor update (FIFO head)
//   init_we/init_hist_we/init_idx   table initialisation sweep
//   busy                            sweep pending or in progress
//   stat_clr, branch_cnt,
//   mispred_cnt                     statistics
module bp_update_ctrl #(
    parameter int unsigned PC_W       = 5,
    parameter int unsigned HIST_W     = 3,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   flush_req,
    input  logic                   upd_valid,
    input  logic [PC_W-1:0]        upd_pc,
    input  logic                   upd_taken,
    input  logic                   upd_mispredict,
    output logic                   upd_ready,
    output logic                   rec_we,
    output logic [PC_W-1:0]        rec_pc,
    output logic                   rec_data,
    output logic                   init_we,
    output logic                   init_hist_we,
    output logic [PC_W+HIST_W-1:0] init_idx,
    output logic                   busy,
    input  logic                   stat_clr,
    output logic [15:0]            branch_cnt,
    output logic [15:0]            mispred_cnt
);

    localparam int unsigned IDX_W  = PC_W + HIST_W;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned STAT_W = 16;

    localparam logic [1:0] S_BOOT  = 2'd0;
    localparam logic [1:0] S_SWEEP = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic            taken;
    } upd_entry_t;

    logic [1:0]       state;
    logic [1:0]       next_state;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;

    upd_entry_t       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] fifo_cnt;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;

    logic [STAT_W-1:0] branch_q;
    logic [STAT_W-1:0] mispred_q;

    // State and sweep index register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_BOOT;
            idx_q <= '0;
        end else begin
            state <= next_state;
            idx_q <= idx_d;
        end
    end

    // Next-state and sweep index; flush restarts from BOOT in any state
    always_comb begin
        next_state = state;
        idx_d      = idx_q;
        case (state)
            S_BOOT: begin
                next_state = S_SWEEP;
                idx_d      = '0;
            end
            S_SWEEP: begin
                if (idx_q == {IDX_W{1'b1}}) begin
                    next_state = S_RUN;
                    idx_d      = '0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_RUN: begin
                next_state = S_RUN;
            end
            default: begin
                next_state = S_BOOT;
                idx_d      = '0;
            end
        endcase
        if (flush_req) begin
            next_state = S_BOOT;
            idx_d      = '0;
        end
    end

    // Sweep and status outputs decoded from state
    assign init_we      = (state == S_SWEEP);
    assign init_hist_we = init_we & (idx_q[HIST_W-1:0] == '0);
    assign init_idx     = idx_q;
    assign busy         = (state != S_RUN);

    // FIFO handshake; full blocks pushes even when a pop happens this cycle
    assign fifo_full  = (fifo_cnt == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (fifo_cnt == '0);
    assign upd_ready  = (state != S_BOOT) & ~fifo_full;
    assign push       = upd_valid & upd_ready;
    assign rec_we     = (state == S_RUN) & ~fifo_empty;
    assign pop        = rec_we;

    // FIFO pointers and occupancy; flush discards the push and the popped head
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else if (flush_req) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // FIFO storage; contents are don't-care while the slot is unoccupied
    always_ff @(posedge clk) begin
        if (push && !flush_req) begin
            fifo_mem[wr_ptr] <= '{pc: upd_pc, taken: upd_taken};
        end
    end

    assign rec_pc   = fifo_mem[rd_ptr].pc;
    assign rec_data = fifo_mem[rd_ptr].taken;

    // Saturating statistics; clear wins over a same-cycle increment
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            branch_q  <= '0;
            mispred_q <= '0;
        end else if (stat_clr) begin
            branch_q  <= '0;
            mispred_q <= '0;
        end else if (push) begin
            if (branch_q != {STAT_W{1'b1}}) begin
                branch_q <= branch_q + STAT_W'(1);
            end
            if (upd_mispredict && (mispred_q != {STAT_W{1'b1}})) begin
                mispred_q <= mispred_q + STAT_W'(1);
            end
        end
    end

    assign branch_cnt  = branch_q;
    assign mispred_cnt = mispred_q;

endmodule
